// File: rtl/signal_mixer.sv
// signal_mixer
//   N-channel audio/test-tone mixer feeding the serial DAC driver.
//   Each channel sample (unsigned offset-binary) is recentred about zero,
//   gated by its enable, attenuated by an arithmetic right shift, then all
//   channels are summed with saturation and recentred again. The result is
//   packed, MSB-aligned, into a 24-bit DAC command word.
//
//   Pipeline: in_valid at cycle N -> out_valid / new sig at cycle N+3.
//   Fully pipelined, no backpressure.
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   sig_in / ch_en / ch_atten valid this cycle
//   sig_in     NUM_CH samples, channel k at [k*SAMPLE_W +: SAMPLE_W]
//   ch_en      per-channel enable
//   ch_atten   per-channel right-shift 0..7, channel k at [k*3 +: 3]
//   clip_clr   clears the sticky clip flag (a same-edge clip event wins)
//   out_valid  one-cycle pulse, sig updated this cycle
//   sig        {DAC_CMD, DAC_ADDR, mixed sample MSB-aligned, zero pad}
//   clip       sticky: a mixed result saturated since last clear/reset
module signal_mixer #(
  parameter int         NUM_CH   = 4,
  parameter int         SAMPLE_W = 12,
  parameter logic [3:0] DAC_CMD  = 4'b0011,
  parameter logic [3:0] DAC_ADDR = 4'b1111
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic [NUM_CH*SAMPLE_W-1:0]   sig_in,
  input  logic [NUM_CH-1:0]            ch_en,
  input  logic [NUM_CH*3-1:0]          ch_atten,
  input  logic                         clip_clr,
  output logic                         out_valid,
  output logic [23:0]                  sig,
  output logic                         clip
);

  // Elaboration-time guard on the supported parameter range.
  if (NUM_CH < 1 || NUM_CH > 8 || SAMPLE_W < 1 || SAMPLE_W > 16) begin : g_param_check
    $error("signal_mixer: NUM_CH must be 1..8 and SAMPLE_W 1..16");
  end

  // Wide enough that the sum of NUM_CH full-scale signed samples never
  // overflows before saturation.
  localparam int SUM_W = SAMPLE_W + $clog2(NUM_CH) + 1;

  // Midscale code; XOR with it flips the MSB, converting offset-binary
  // to two's complement and back.
  localparam logic [SAMPLE_W-1:0] MID = SAMPLE_W'(1) << (SAMPLE_W - 1);

  localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'((1 << (SAMPLE_W - 1)) - 1);
  localparam logic signed [SUM_W-1:0] SAT_MIN = ~SAT_MAX;

  localparam logic [SAMPLE_W-1:0] SAMPLE_MAX = SAT_MAX[SAMPLE_W-1:0];
  localparam logic [SAMPLE_W-1:0] SAMPLE_MIN = SAT_MIN[SAMPLE_W-1:0];

  // Midscale MSB-aligned in a 16-bit field is always bit 15 alone.
  localparam logic [23:0] RESET_WORD = {DAC_CMD, DAC_ADDR, 16'h8000};

  // ---------------------------------------------------------------
  // Stage 1: per-channel recentre, enable gate, attenuation
  // ---------------------------------------------------------------
  logic                    s1_valid_reg;
  logic signed [SUM_W-1:0] s1_ext [NUM_CH];

  genvar gi;
  for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic        [SAMPLE_W-1:0] raw;
    logic signed [SAMPLE_W-1:0] centered;
    logic signed [SAMPLE_W-1:0] shifted;
    logic signed [SAMPLE_W-1:0] s_reg;

    assign raw      = sig_in[gi*SAMPLE_W +: SAMPLE_W];
    assign centered = $signed(raw ^ MID);
    // Arithmetic shift floors toward minus infinity (-1 >>> n == -1).
    assign shifted  = centered >>> ch_atten[gi*3 +: 3];

    always_ff @(posedge clk) begin
      if (rst) begin
        s_reg <= '0;
      end else if (in_valid) begin
        s_reg <= ch_en[gi] ? shifted : '0;
      end
    end

    assign s1_ext[gi] = {{(SUM_W-SAMPLE_W){s_reg[SAMPLE_W-1]}}, s_reg};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_reg <= 1'b0;
    end else begin
      s1_valid_reg <= in_valid;
    end
  end

  // ---------------------------------------------------------------
  // Stage 2: sum and saturate
  // ---------------------------------------------------------------
  logic signed [SUM_W-1:0]    sum_next;
  logic                       sat_hi;
  logic                       sat_lo;
  logic        [SAMPLE_W-1:0] mixed_next;

  always_comb begin
    sum_next = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      sum_next = sum_next + s1_ext[k];
    end
  end

  always_comb begin
    sat_hi     = (sum_next > SAT_MAX);
    sat_lo     = (sum_next < SAT_MIN);
    mixed_next = sum_next[SAMPLE_W-1:0];
    if (sat_hi) begin
      mixed_next = SAMPLE_MAX;
    end else if (sat_lo) begin
      mixed_next = SAMPLE_MIN;
    end
  end

  logic                s2_valid_reg;
  logic [SAMPLE_W-1:0] s2_sample_reg;
  logic                s2_sat_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_reg  <= 1'b0;
      s2_sample_reg <= '0;
      s2_sat_reg    <= 1'b0;
    end else begin
      s2_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        s2_sample_reg <= mixed_next;
        s2_sat_reg    <= sat_hi | sat_lo;
      end
    end
  end

  // ---------------------------------------------------------------
  // Stage 3: recentre, pack, sticky clip
  // ---------------------------------------------------------------
  logic [15:0] field_next;
  logic        out_valid_reg;
  logic [23:0] sig_reg;
  logic        clip_reg;

  assign field_next = 16'(s2_sample_reg ^ MID) << (16 - SAMPLE_W);

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      sig_reg       <= RESET_WORD;
      clip_reg      <= 1'b0;
    end else begin
      out_valid_reg <= s2_valid_reg;
      if (s2_valid_reg) begin
        sig_reg <= {DAC_CMD, DAC_ADDR, field_next};
      end
      // A saturating result takes priority over a simultaneous clear.
      if (s2_valid_reg && s2_sat_reg) begin
        clip_reg <= 1'b1;
      end else if (clip_clr) begin
        clip_reg <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign sig       = sig_reg;
  assign clip      = clip_reg;

endmodule

// File: tb/tb_signal_mixer.sv
// Directed, table-driven bench for signal_mixer (NUM_CH=4, SAMPLE_W=12).
// Expected DAC words are hand-computed from the mixing rules.
module tb_signal_mixer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [47:0] sig_in;
  logic [3:0]  ch_en;
  logic [11:0] ch_atten;
  logic        clip_clr;
  logic        out_valid;
  logic [23:0] sig;
  logic        clip;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  signal_mixer #(
    .NUM_CH   (4),
    .SAMPLE_W (12),
    .DAC_CMD  (4'b0011),
    .DAC_ADDR (4'b1111)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .sig_in    (sig_in),
    .ch_en     (ch_en),
    .ch_atten  (ch_atten),
    .clip_clr  (clip_clr),
    .out_valid (out_valid),
    .sig       (sig),
    .clip      (clip)
  );

  typedef struct {
    string       name;
    logic [3:0]  en;
    logic [11:0] atten;
    logic [47:0] smp;      // {ch3, ch2, ch1, ch0}
    logic [23:0] exp_sig;
    logic        exp_sat;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic set_vec(input int i, input string n, input logic [3:0] en,
                         input logic [11:0] at, input logic [47:0] smp,
                         input logic [23:0] es, input logic sat);
    vecs[i].name    = n;
    vecs[i].en      = en;
    vecs[i].atten   = at;
    vecs[i].smp     = smp;
    vecs[i].exp_sig = es;
    vecs[i].exp_sat = sat;
  endtask

  // One input pulse, then wait (bounded) for out_valid. lat=1 is the
  // first falling edge after the capture edge; the expected latency is 3.
  // With clr_land, clip_clr is held across the edge where the result lands.
  task automatic send_wait(input logic [3:0] en, input logic [11:0] at,
                           input logic [47:0] smp, input bit clr_land,
                           output int lat);
    @(negedge clk);
    in_valid = 1'b1;
    ch_en    = en;
    ch_atten = at;
    sig_in   = smp;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      if (clr_land && lat == 2) clip_clr = 1'b1;
      @(negedge clk);
      lat++;
    end
    clip_clr = 1'b0;
  endtask

  task automatic clear_clip();
    @(negedge clk);
    clip_clr = 1'b1;
    @(negedge clk);
    clip_clr = 1'b0;
  endtask

  initial begin
    int lat;
    int nvalid;
    logic [23:0] exp_word;

    set_vec(0, "single_ch0", 4'h1, 12'h000, {12'hFFF, 12'hFFF, 12'hFFF, 12'hA00}, 24'h3FA000, 1'b0);
    set_vec(1, "sat_pos",    4'h3, 12'h000, {12'h000, 12'h000, 12'hC00, 12'hC00}, 24'h3FFFF0, 1'b1);
    set_vec(2, "att1_ch1",   4'h2, 12'h008, {12'h000, 12'h000, 12'h000, 12'h000}, 24'h3F4000, 1'b0);
    set_vec(3, "att3_floor", 4'h4, 12'h0C0, {12'h000, 12'h7FF, 12'h000, 12'h000}, 24'h3F7FF0, 1'b0);
    set_vec(4, "four_att2",  4'hF, 12'h492, {12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF}, 24'h3FFFC0, 1'b0);
    set_vec(5, "all_off",    4'h0, 12'h000, {12'hFFF, 12'hFFF, 12'h000, 12'h000}, 24'h3F8000, 1'b0);
    set_vec(6, "sat_neg",    4'h3, 12'h000, {12'hFFF, 12'hFFF, 12'h000, 12'h000}, 24'h3F0000, 1'b1);
    set_vec(7, "two_sum",    4'h3, 12'h000, {12'h000, 12'h000, 12'h880, 12'h900}, 24'h3F9800, 1'b0);
    set_vec(8, "att7_floor", 4'h1, 12'h007, {12'h000, 12'h000, 12'h000, 12'h123}, 24'h3F7F20, 1'b0);

    rst      = 1'b1;
    in_valid = 1'b0;
    sig_in   = '0;
    ch_en    = '0;
    ch_atten = '0;
    clip_clr = 1'b0;

    // Reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset_sig", 32'(sig), 32'h3F8000);
    check("reset_out_valid", 32'(out_valid), 32'h0);
    check("reset_clip", 32'(clip), 32'h0);
    nvalid = 0;
    repeat (5) begin
      @(negedge clk);
      if (out_valid) nvalid++;
    end
    check("idle_no_valid", 32'(nvalid), 32'h0);

    // Table of single transactions; clip cleared after each.
    for (int i = 0; i < 9; i++) begin
      send_wait(vecs[i].en, vecs[i].atten, vecs[i].smp, 1'b0, lat);
      check({vecs[i].name, "_latency"}, 32'(lat), 32'd3);
      check({vecs[i].name, "_sig"}, 32'(sig), 32'(vecs[i].exp_sig));
      check({vecs[i].name, "_clip"}, 32'(clip), 32'(vecs[i].exp_sat));
      @(negedge clk);
      check({vecs[i].name, "_single_pulse"}, 32'(out_valid), 32'h0);
      clear_clip();
      check({vecs[i].name, "_clip_cleared"}, 32'(clip), 32'h0);
    end

    // Sticky clip across a later clean sample
    send_wait(vecs[1].en, vecs[1].atten, vecs[1].smp, 1'b0, lat);
    check("sticky_set", 32'(clip), 32'h1);
    send_wait(vecs[0].en, vecs[0].atten, vecs[0].smp, 1'b0, lat);
    check("sticky_clean_sig", 32'(sig), 32'h3FA000);
    check("sticky_hold", 32'(clip), 32'h1);
    clear_clip();
    check("sticky_cleared", 32'(clip), 32'h0);

    // clip_clr on the same edge as a saturating result: set wins
    send_wait(vecs[6].en, vecs[6].atten, vecs[6].smp, 1'b1, lat);
    check("collide_latency", 32'(lat), 32'd3);
    check("collide_sig", 32'(sig), 32'h3F0000);
    check("collide_clip", 32'(clip), 32'h1);
    @(negedge clk);
    check("collide_clip_after", 32'(clip), 32'h1);
    clear_clip();

    // Hold: sig keeps last value while idle
    repeat (3) @(negedge clk);
    check("hold_sig", 32'(sig), 32'h3F0000);

    // Streaming ramp 0x800..0x807 on ch0, one per cycle
    ch_en    = 4'h1;
    ch_atten = 12'h000;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (c >= 3 && c <= 10) begin
        exp_word = {8'h3F, 12'(12'h800 + c - 3), 4'h0};
        check($sformatf("stream_valid_%0d", c), 32'(out_valid), 32'h1);
        check($sformatf("stream_sig_%0d", c), 32'(sig), 32'(exp_word));
      end else begin
        check($sformatf("stream_idle_%0d", c), 32'(out_valid), 32'h0);
      end
      if (c < 8) begin
        in_valid = 1'b1;
        sig_in   = {36'h0, 12'(12'h800 + c)};
      end else begin
        in_valid = 1'b0;
      end
    end

    // Make clip set so the reset below has something to clear
    send_wait(vecs[1].en, vecs[1].atten, vecs[1].smp, 1'b0, lat);
    check("pre_reset_clip", 32'(clip), 32'h1);

    // Two inputs, then reset the cycle after the 2nd: nothing emerges
    ch_en    = 4'h1;
    ch_atten = 12'h000;
    nvalid   = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (out_valid) nvalid++;
      in_valid = (c < 2);
      sig_in   = {36'h0, 12'(12'hA00 + c)};
      rst      = (c == 2);
    end
    in_valid = 1'b0;
    check("midreset_no_valid", 32'(nvalid), 32'h0);
    check("midreset_sig", 32'(sig), 32'h3F8000);
    check("midreset_clip", 32'(clip), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/signal_mixer.md
Name: signal_mixer

Overview:
- Parametrised N-channel mixer replacing single-source selection between sine and square.
- Sits between the oscillator blocks and the serial DAC driver.
- Per channel: enable and 3-bit attenuation. Enabled channels are summed about midscale with saturation.
- Result is packed into the 24-bit DAC command word, with a valid strobe and a sticky clip flag.

Parameters:
- NUM_CH, 4, number of input channels (1..8).
- SAMPLE_W, 12, sample width, unsigned offset-binary (1..16).
- DAC_CMD, 4'b0011, DAC command nibble placed in sig[23:20].
- DAC_ADDR, 4'b1111, DAC address nibble placed in sig[19:16].

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  sig_in, ch_en and ch_atten are valid this cycle.
- sig_in  in  NUM_CH*SAMPLE_W  channel samples; channel k at [k*SAMPLE_W +: SAMPLE_W].
- ch_en  in  NUM_CH  per-channel enable.
- ch_atten  in  NUM_CH*3  per-channel right-shift amount 0..7; channel k at [k*3 +: 3].
- clip_clr  in  1  clears sticky clip flag.
- out_valid  out  1  one-cycle pulse, sig updated this cycle.
- sig  out  24  DAC word {DAC_CMD, DAC_ADDR, mixed sample MSB-aligned in [15:16-SAMPLE_W], zeros below}.
- clip  out  1  sticky: a mixed result saturated since last clear or reset.

Behaviour:
- Clock and reset: one clock domain, clk. Reset is synchronous and active-high on rst.
- Reset values:
  - sig = {DAC_CMD, DAC_ADDR, midscale, zeros}. Default = 24'h3F8000, where midscale = 1<<(SAMPLE_W-1).
  - out_valid = 0, clip = 0.
  - All pipeline valid bits = 0.
- Pipeline: 3 stages. in_valid at cycle N gives out_valid and new sig at cycle N+3.
  - Fully pipelined: accepts in_valid every cycle; no backpressure.
  - Control inputs (ch_en, ch_atten) are captured together with the data on in_valid.
- Stage 1, per channel:
  - Convert to signed: s = sample - midscale (MSB invert).
  - If ch_en[k]=0: s = 0.
  - Else: s = s >>> atten, arithmetic shift, floor toward minus infinity. Example: -1 >>> 3 = -1.
- Stage 2:
  - Sum all channels in SAMPLE_W + clog2(NUM_CH) + 1 signed bits; no intermediate overflow.
  - Saturate to [-2^(SAMPLE_W-1), 2^(SAMPLE_W-1)-1].
  - Flag sat = 1 when the sum lies outside that range.
- Stage 3:
  - Add midscale back (MSB invert).
  - Pack into sig and pulse out_valid.
  - If sat: set clip.
- Hold behaviour: when no valid reaches stage 3, sig holds its last value and out_valid = 0.
- Clip flag:
  - clip_clr=1 clears clip on the next edge.
  - If clip_clr and a saturating result land on the same edge, set wins and clip = 1.
- Channel edge cases:
  - All channels disabled gives exact midscale.
  - NUM_CH=1 with attenuation 0 passes the sample through unchanged and never clips.
- Reset mid-operation: all in-flight samples are discarded. No out_valid is produced for them, and sig returns to the reset word.
- Parameter limits: SAMPLE_W > 16 or NUM_CH outside 1..8 is illegal; an elaboration-time check is required.

Test Plan:
1. Reset:
   - Assert rst 2 cycles, then observe.
   - Expect sig = 24'h3F8000, out_valid = 0, clip = 0.
   - No out_valid for 5 idle cycles.
2. Single channel:
   - ch_en = 4'b0001, atten = 0, ch0 = 12'hA00, others = 12'hFFF, one in_valid pulse.
   - Expect exactly one out_valid, 3 cycles later.
   - Expect sig = 24'h3FA000 (disabled channels ignored).
3. Saturation:
   - ch0 = ch1 = 12'hC00, ch_en = 4'b0011, atten = 0.
   - Expect sig = 24'h3FFFF0, clip = 1.
   - clip stays 1 across later clean samples.
   - clip_clr on the same cycle as a new saturating out_valid leaves clip = 1.
4. Attenuation:
   - ch1 = 12'h000 with atten 1 gives sig = 24'h3F4000.
   - ch2 = 12'h7FF with atten 3 gives sig = 24'h3F7FF0 (floor).
   - Four channels at 12'hFFF with atten 2 sum to 2044 and give sig = 24'h3FFFC0, no clip.
5. Streaming and reset:
   - in_valid every cycle for 8 samples with ramp 12'h800..12'h807 on ch0.
   - Expect 8 consecutive out_valid pulses in order.
   - Repeat, asserting rst at the cycle after the 2nd input.
   - Expect no output for in-flight samples and sig = 24'h3F8000.
